// File: rtl/lut_xlate_if.sv
// lut_xlate_if: bus bundle for the byte-translation stage.
//   wr_en/wr_addr/wr_data       : single-entry table write port
//   in_valid/in_ready/in_data   : address stream into the block
//   out_valid/out_ready/out_data: translated-byte stream out of the block
// master = table owner / stream source+sink, slave = lut_xlate.
interface lut_xlate_if #(
    parameter int DW = 8,
    parameter int AW = 8
);
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;

    modport master (
        output wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/lut_xlate.sv
// lut_xlate: 2**AW x DW lookup table with identity fill after reset and a
// valid/ready translation stream (1-cycle latency, 2-entry output FIFO).
// Ports:
//   clock       : rising-edge clock
//   reset       : synchronous, active-high; flushes FIFO and restarts the fill
//   bus         : lut_xlate_if.slave (write port, input stream, output stream)
//   init_busy   : identity fill in progress
//   xlate_count : results delivered (popped), saturating at 16'hFFFF
module lut_xlate #(
    parameter int DW = 8,
    parameter int AW = 8
) (
    input  logic        clock,
    input  logic        reset,
    lut_xlate_if.slave  bus,
    output logic        init_busy,
    output logic [15:0] xlate_count
);
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t        state, state_nx;
    logic [AW-1:0] fill_cnt;
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] fifo [2];
    logic          wptr, rptr;
    logic [1:0]    fcount;
    logic          push, pop;

    always_ff @(posedge clock) begin
        if (reset) state <= S_INIT;
        else       state <= state_nx;
    end

    // in_ready depends only on registered state, so there is no
    // combinational path from out_ready; a full FIFO refuses input even
    // when it is being popped in the same cycle.
    always_comb begin
        state_nx     = state;
        init_busy    = 1'b0;
        bus.in_ready = 1'b0;
        case (state)
            S_INIT: begin
                init_busy = 1'b1;
                if (&fill_cnt) state_nx = S_RUN;
            end
            S_RUN:   bus.in_ready = (fcount != 2'd2);
            default: state_nx = S_INIT;
        endcase
    end

    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = bus.out_valid && bus.out_ready;
    assign bus.out_valid = (fcount != 2'd0);
    assign bus.out_data  = fifo[rptr];

    always_ff @(posedge clock) begin
        if (reset)                 fill_cnt <= '0;
        else if (state == S_INIT)  fill_cnt <= fill_cnt + 1'b1;
    end

    // Table storage. The fill owns the write port during INIT; run-time
    // writes are only honoured in RUN.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (state == S_INIT)  mem[fill_cnt]    <= DW'(fill_cnt);
            else if (bus.wr_en)   mem[bus.wr_addr] <= bus.wr_data;
        end
    end

    // Output FIFO. The table read is taken before this edge's write lands,
    // so a same-cycle write to the accepted address yields the old entry.
    always_ff @(posedge clock) begin
        if (reset) begin
            fifo[0]     <= '0;
            fifo[1]     <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            fcount      <= 2'd0;
            xlate_count <= 16'd0;
        end else begin
            if (push) begin
                fifo[wptr] <= mem[bus.in_data];
                wptr       <= ~wptr;
            end
            if (pop) begin
                rptr <= ~rptr;
                if (xlate_count != 16'hFFFF) xlate_count <= xlate_count + 16'd1;
            end
            case ({push, pop})
                2'b10:   fcount <= fcount + 2'd1;
                2'b01:   fcount <= fcount - 2'd1;
                default: fcount <= fcount;
            endcase
        end
    end
endmodule
